// File: rtl/pattern_pkg.sv
// pattern_pkg: shared types, depth-test rectangles and the pixel colour/depth function
package pattern_pkg;
  typedef enum logic [1:0] {PatSolid, PatChecker, PatGradient, PatDepth} pat_mode_t;
  typedef enum logic [2:0] {StIdle, StLoad, StEmit, StNextPass, StDone} state_t;
  localparam logic [8:0]  A_X0  = 9'd40;
  localparam logic [8:0]  A_X1  = 9'd199;
  localparam logic [7:0]  A_Y0  = 8'd40;
  localparam logic [7:0]  A_Y1  = 8'd159;
  localparam logic [11:0] A_RGB = 12'hF00;
  localparam logic [15:0] A_Z   = 16'h4000;
  localparam logic [8:0]  B_X0  = 9'd120;
  localparam logic [8:0]  B_X1  = 9'd279;
  localparam logic [7:0]  B_Y0  = 8'd80;
  localparam logic [7:0]  B_Y1  = 8'd199;
  localparam logic [11:0] B_RGB = 12'h00F;
  localparam logic [15:0] B_Z   = 16'h2000;
  // returns {z, rgb} for the pixel about to be presented
  function automatic logic [27:0] pixel_fn(input pat_mode_t m, input logic [11:0] c, input logic pass,
                                           input logic [8:0] x, input logic [7:0] y, input logic [15:0] flat_z);
    logic [11:0] rgb;
    rgb = (m == PatChecker)  ? ((x[3] ^ y[3]) ? c : ~c) :
          (m == PatGradient) ? {x[7:4], y[7:4], c[3:0]} : c;
    return (m == PatDepth) ? (pass ? {B_Z, B_RGB} : {A_Z, A_RGB}) : {flat_z, rgb};
  endfunction
endpackage

// File: rtl/pixel_scanner.sv
// pixel_scanner: row-major bounded x/y counter with reload, advance and last-pixel flag
module pixel_scanner
  import pattern_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       load,
  input  logic       advance,
  input  logic [8:0] x0,
  input  logic [8:0] x1,
  input  logic [7:0] y0,
  input  logic [7:0] y1,
  output logic [8:0] nx,
  output logic [7:0] ny,
  output logic       last
);
  logic [8:0] x, lx0, lx1;
  logic [7:0] y, ly1;
  logic       row_end;
  // next coordinates follow raster order inside the latched rectangle
  always_comb begin
    row_end = x == lx1;
    nx = row_end ? lx0 : x + 9'd1;
    ny = row_end ? y + 8'd1 : y;
    last = row_end && (y == ly1);
  end
  // counters hold the pixel currently on the outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x <= '0;
      y <= '0;
      lx0 <= '0;
      lx1 <= '0;
      ly1 <= '0;
    end else if (load) begin
      x <= x0;
      y <= y0;
      lx0 <= x0;
      lx1 <= x1;
      ly1 <= y1;
    end else if (advance) begin
      x <= nx;
      y <= ny;
    end
  end
endmodule

// File: rtl/pixel_pattern_source.sv
// pixel_pattern_source: generates test frames onto the framebuffer pixel valid/ready interface
module pixel_pattern_source
  import pattern_pkg::*;
#(
  parameter int          SCREEN_W = 320,
  parameter int          SCREEN_H = 240,
  parameter logic [15:0] FLAT_Z   = 16'h8000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [1:0]  mode_in,
  input  logic [11:0] color_in,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [8:0]  x_out,
  output logic [7:0]  y_out,
  output logic [15:0] z_out,
  output logic [11:0] rgb_out,
  output logic        busy_out,
  output logic        done_out,
  output logic [15:0] frame_count_out
);
  state_t      state;
  pat_mode_t   mode_q;
  logic [11:0] color_q;
  logic        pass_q, depth, load, xfer, advance, last;
  logic [8:0]  bx0, bx1, nx, px;
  logic [7:0]  by0, by1, ny, py;
  logic [27:0] pv;
  // pass rectangle, scanner control and the pixel to register next
  always_comb begin
    depth = mode_q == PatDepth;
    bx0 = depth ? (pass_q ? B_X0 : A_X0) : 9'd0;
    bx1 = depth ? (pass_q ? B_X1 : A_X1) : 9'(SCREEN_W - 1);
    by0 = depth ? (pass_q ? B_Y0 : A_Y0) : 8'd0;
    by1 = depth ? (pass_q ? B_Y1 : A_Y1) : 8'(SCREEN_H - 1);
    load = (state == StLoad) || (state == StNextPass);
    xfer = (state == StEmit) && valid_out && ready_in;
    advance = xfer && !last;
    px = load ? bx0 : nx;
    py = load ? by0 : ny;
    pv = pixel_fn(mode_q, color_q, pass_q, px, py, FLAT_Z);
  end
  pixel_scanner u_scanner (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .load    (load),
    .advance (advance),
    .x0      (bx0),
    .x1      (bx1),
    .y0      (by0),
    .y1      (by1),
    .nx      (nx),
    .ny      (ny),
    .last    (last)
  );
  // frame sequencing with registered pixel and status outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= StIdle;
      mode_q <= PatSolid;
      color_q <= '0;
      pass_q <= 1'b0;
      valid_out <= 1'b0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
      rgb_out <= '0;
      frame_count_out <= '0;
    end else begin
      done_out <= 1'b0;
      case (state)
        StIdle: if (start_in) begin
          mode_q <= pat_mode_t'(mode_in);
          color_q <= color_in;
          pass_q <= 1'b0;
          busy_out <= 1'b1;
          state <= StLoad;
        end
        StLoad, StNextPass: begin
          valid_out <= 1'b1;
          x_out <= px;
          y_out <= py;
          {z_out, rgb_out} <= pv;
          state <= StEmit;
        end
        StEmit: if (xfer) begin
          if (!last) begin
            x_out <= px;
            y_out <= py;
            {z_out, rgb_out} <= pv;
          end else if (depth && !pass_q) begin
            valid_out <= 1'b0;
            pass_q <= 1'b1;
            state <= StNextPass;
          end else begin
            valid_out <= 1'b0;
            busy_out <= 1'b0;
            done_out <= 1'b1;
            frame_count_out <= frame_count_out + 16'd1;
            state <= StDone;
          end
        end
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_pattern_source.sv
// tb_pixel_pattern_source: directed frame checks on a reduced 40x20 screen plus a full depth-test frame
module tb_pixel_pattern_source;
  localparam int W = 40;
  localparam int H = 20;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_in = 1'b0;
  logic [1:0]  mode_in = '0;
  logic [11:0] color_in = '0;
  logic        ready_in = 1'b0;
  logic        valid_out, busy_out, done_out;
  logic [8:0]  x_out;
  logic [7:0]  y_out;
  logic [15:0] z_out, frame_count_out;
  logic [11:0] rgb_out;
  int          tests = 0;
  int          fails = 0;
  int          exp_fc = 0;
  logic [44:0] cap_first, cap_last;
  logic [11:0] cap80, cap88;

  pixel_pattern_source #(.SCREEN_W(W), .SCREEN_H(H), .FLAT_Z(16'h8000)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .start_in        (start_in),
    .mode_in         (mode_in),
    .color_in        (color_in),
    .valid_out       (valid_out),
    .ready_in        (ready_in),
    .x_out           (x_out),
    .y_out           (y_out),
    .z_out           (z_out),
    .rgb_out         (rgb_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .frame_count_out (frame_count_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] ref_pix(input logic [1:0] m, input logic [11:0] c, input int p, input int x, input int y);
    logic [8:0] xv;
    logic [7:0] yv;
    xv = 9'(x);
    yv = 8'(y);
    case (m)
      2'd0: return {16'h8000, c};
      2'd1: return {16'h8000, (xv[3] ^ yv[3]) ? c : ~c};
      2'd2: return {16'h8000, xv[7:4], yv[7:4], c[3:0]};
      default: return (p != 0) ? {16'h2000, 12'h00F} : {16'h4000, 12'hF00};
    endcase
  endfunction

  task automatic run_frame(input logic [1:0] m, input logic [11:0] c, input bit bp, input int exp_n, input int inj);
    int n, gaps, k, p, ex, ey, x0, x1, y1, bound;
    bit bad, pend, seen;
    logic [44:0] cur, held, expv;
    mode_in = m;
    color_in = c;
    start_in = 1'b1;
    tick;
    start_in = 1'b0;
    chk("load_valid", valid_out, 0);
    chk("load_busy", busy_out, 1);
    tick;
    chk("first_valid", valid_out, 1);
    p = 0;
    ex = (m == 2'd3) ? 40 : 0;
    ey = ex;
    n = 0; gaps = 0; k = 0; bad = 0; pend = 0; seen = 0;
    held = '0;
    bound = 3 * exp_n + 100;
    while (!seen && k < bound) begin
      ready_in = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inj > 0 && k == inj) begin
        start_in = 1'b1;
        mode_in = m ^ 2'd1;
      end else start_in = 1'b0;
      cur = {x_out, y_out, z_out, rgb_out};
      if (pend && !bad) begin
        bad = {valid_out, cur} !== {1'b1, held};
        chk("hold_stable", {valid_out, cur}, {1'b1, held});
      end
      if (done_out) seen = 1;
      else if (valid_out && ready_in) begin
        expv = {9'(ex), 8'(ey), ref_pix(m, c, p, ex, ey)};
        if (!bad) begin
          bad = cur !== expv;
          chk("pixel", cur, expv);
        end
        if (n == 0) cap_first = cur;
        cap_last = cur;
        if (x_out == 9'd8 && y_out == 8'd0) cap80 = rgb_out;
        if (x_out == 9'd8 && y_out == 8'd8) cap88 = rgb_out;
        n++;
        x0 = (m == 2'd3) ? ((p != 0) ? 120 : 40) : 0;
        x1 = (m == 2'd3) ? ((p != 0) ? 279 : 199) : W - 1;
        y1 = (m == 2'd3) ? ((p != 0) ? 199 : 159) : H - 1;
        if (ex == x1) begin
          ex = x0;
          if (ey != y1) ey++;
          else if (m == 2'd3 && p == 0) begin
            p = 1;
            ex = 120;
            ey = 80;
          end
        end else ex++;
      end else if (!valid_out) gaps++;
      pend = valid_out && !ready_in;
      held = cur;
      if (!seen) begin
        tick;
        k++;
      end
    end
    start_in = 1'b0;
    chk("done_seen", seen, 1);
    chk("transfers", n, exp_n);
    chk("pass_gaps", gaps, (m == 2'd3) ? 1 : 0);
    if (!bp) chk("done_cycle", k, exp_n + ((m == 2'd3) ? 1 : 0));
    exp_fc++;
    chk("frame_count", frame_count_out, exp_fc);
    chk("done_busy", busy_out, 0);
    tick;
    chk("done_pulse", {done_out, valid_out, busy_out}, 0);
  endtask

  initial begin
    tick;
    tick;
    rst = 1'b0;
    chk("reset_state", {valid_out, busy_out, done_out, x_out, y_out, z_out, rgb_out, frame_count_out}, 0);
    tick;
    chk("idle_quiet", {valid_out, busy_out, done_out}, 0);

    run_frame(2'd0, 12'h0F0, 0, W * H, 0);
    chk("m0_first", cap_first, {9'd0, 8'd0, 16'h8000, 12'h0F0});
    chk("m0_last", cap_last, {9'd39, 8'd19, 16'h8000, 12'h0F0});

    run_frame(2'd1, 12'h123, 0, W * H, 0);
    chk("m1_first", cap_first, {9'd0, 8'd0, 16'h8000, 12'hEDC});
    chk("m1_8_0", cap80, 12'h123);
    chk("m1_8_8", cap88, 12'hEDC);
    chk("m1_last", cap_last, {9'd39, 8'd19, 16'h8000, 12'hEDC});

    run_frame(2'd3, 12'h777, 0, 38400, 0);
    chk("m3_first", cap_first, {9'd40, 8'd40, 16'h4000, 12'hF00});
    chk("m3_last", cap_last, {9'd279, 8'd199, 16'h2000, 12'h00F});

    run_frame(2'd2, 12'hABC, 1, W * H, 0);
    chk("m2_8_0", cap80, 12'h00C);
    chk("m2_last", cap_last, {9'd39, 8'd19, 16'h8000, 12'h21C});

    run_frame(2'd0, 12'h5A5, 0, W * H, 100);
    chk("ignore_start_last", cap_last, {9'd39, 8'd19, 16'h8000, 12'h5A5});
    chk("ignore_start_idle", busy_out, 0);

    mode_in = 2'd2;
    color_in = 12'h111;
    start_in = 1'b1;
    ready_in = 1'b1;
    tick;
    start_in = 1'b0;
    for (int i = 0; i < 30; i++) tick;
    chk("midframe_busy", {valid_out, busy_out}, 2'b11);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_state", {valid_out, busy_out, done_out, x_out, y_out, frame_count_out}, 0);
    exp_fc = 0;
    run_frame(2'd0, 12'h456, 0, W * H, 0);
    chk("post_reset_first", cap_first, {9'd0, 8'd0, 16'h8000, 12'h456});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
